// File: rtl/conv_layer_scheduler_pkg.sv
// Shared definitions for the Conv2D layer scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_layer_scheduler_pkg;

  localparam int SRAM_ADDR_W = 16;
  localparam int MAX_CIN     = 64;
  localparam int MAX_TILES   = 16;
  localparam int CIN_W       = $clog2(MAX_CIN + 1);
  localparam int TILE_W      = $clog2(MAX_TILES + 1);

  // One input-channel plane of the activation image
  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int CH_STRIDE   = IMG_W * IMG_H;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_W     = 3'd1,
    LAUNCH     = 3'd2,
    STREAM     = 3'd3,
    DRAIN      = 3'd4,
    WAIT_DRAIN = 3'd5,
    DONE       = 3'd6
  } conv_sched_state_e;

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Bundles the scheduler's control, weight-load, generator and drain handshakes.
// Latency: n/a (wiring only).
// Backpressure: req held until ack; start/last/drain signals are single-cycle pulses.
interface conv_layer_scheduler_if #(
  parameter int SRAM_ADDR_W = conv_layer_scheduler_pkg::SRAM_ADDR_W,
  parameter int CIN_W       = conv_layer_scheduler_pkg::CIN_W,
  parameter int TILE_W      = conv_layer_scheduler_pkg::TILE_W
);
  // layer control
  logic                   start_i;
  logic [SRAM_ADDR_W-1:0] cfg_img_base_i;
  logic [CIN_W-1:0]       cfg_num_cin_i;
  logic [TILE_W-1:0]      cfg_num_tiles_i;
  logic                   busy_o;
  logic                   done_o;
  // weight loader
  logic                   wload_req_o;
  logic [TILE_W-1:0]      wload_tile_o;
  logic [CIN_W-1:0]       wload_cin_o;
  logic                   wload_ack_i;
  // im2col address generator
  logic                   gen_start_o;
  logic [SRAM_ADDR_W-1:0] gen_base_addr_o;
  logic                   gen_last_i;
  // accumulators / drain
  logic                   acc_first_o;
  logic                   acc_last_o;
  logic                   drain_start_o;
  logic                   drain_done_i;

  // scheduler side
  modport master (
    input  start_i, cfg_img_base_i, cfg_num_cin_i, cfg_num_tiles_i,
           wload_ack_i, gen_last_i, drain_done_i,
    output busy_o, done_o, wload_req_o, wload_tile_o, wload_cin_o,
           gen_start_o, gen_base_addr_o, acc_first_o, acc_last_o, drain_start_o
  );

  // layer FSM / loader / generator / drain side
  modport slave (
    output start_i, cfg_img_base_i, cfg_num_cin_i, cfg_num_tiles_i,
           wload_ack_i, gen_last_i, drain_done_i,
    input  busy_o, done_o, wload_req_o, wload_tile_o, wload_cin_o,
           gen_start_o, gen_base_addr_o, acc_first_o, acc_last_o, drain_start_o
  );

endinterface

// File: rtl/conv_layer_scheduler.sv
// Sequences one Conv2D layer: per tile, per input channel load weights, stream the plane, then drain.
// Latency: 1 cycle from every accepted handshake input to the next request/pulse; 3 cycles overhead per channel.
// Backpressure: waits indefinitely on wload_ack_i, gen_last_i and drain_done_i; stray pulses are dropped.
module conv_layer_scheduler #(
  parameter int  SRAM_ADDR_W = conv_layer_scheduler_pkg::SRAM_ADDR_W,
  parameter int  MAX_CIN     = conv_layer_scheduler_pkg::MAX_CIN,
  parameter int  MAX_TILES   = conv_layer_scheduler_pkg::MAX_TILES,
  parameter int  CH_STRIDE   = conv_layer_scheduler_pkg::CH_STRIDE,
  localparam int CIN_W       = $clog2(MAX_CIN + 1),
  localparam int TILE_W      = $clog2(MAX_TILES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_async_i,
  conv_layer_scheduler_if.master sched
);
  import conv_layer_scheduler_pkg::*;

  // Stride folded to address width so the plane walk wraps modulo the SRAM size
  localparam logic [SRAM_ADDR_W-1:0] STRIDE_A = SRAM_ADDR_W'(CH_STRIDE);

  conv_sched_state_e      state_q, state_d;
  logic [CIN_W-1:0]       num_cin_q, num_cin_d;
  logic [TILE_W-1:0]      num_tiles_q, num_tiles_d;
  logic [SRAM_ADDR_W-1:0] img_base_q, img_base_d;
  logic [CIN_W-1:0]       cin_cnt_q, cin_cnt_d;
  logic [TILE_W-1:0]      tile_cnt_q, tile_cnt_d;
  logic [SRAM_ADDR_W-1:0] ch_base_q, ch_base_d;
  logic [SRAM_ADDR_W-1:0] gen_base_q, gen_base_d;
  logic                   in_channel;

  // State, latched config, counters and address registers
  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_q     <= IDLE;
      num_cin_q   <= '0;
      num_tiles_q <= '0;
      img_base_q  <= '0;
      cin_cnt_q   <= '0;
      tile_cnt_q  <= '0;
      ch_base_q   <= '0;
      gen_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      num_cin_q   <= num_cin_d;
      num_tiles_q <= num_tiles_d;
      img_base_q  <= img_base_d;
      cin_cnt_q   <= cin_cnt_d;
      tile_cnt_q  <= tile_cnt_d;
      ch_base_q   <= ch_base_d;
      gen_base_q  <= gen_base_d;
    end
  end

  // Next-state, counter updates and pulse outputs
  always_comb begin
    state_d              = state_q;
    num_cin_d            = num_cin_q;
    num_tiles_d          = num_tiles_q;
    img_base_d           = img_base_q;
    cin_cnt_d            = cin_cnt_q;
    tile_cnt_d           = tile_cnt_q;
    ch_base_d            = ch_base_q;
    gen_base_d           = gen_base_q;
    sched.wload_req_o    = 1'b0;
    sched.gen_start_o    = 1'b0;
    sched.drain_start_o  = 1'b0;
    sched.done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sched.start_i) begin
          num_cin_d   = sched.cfg_num_cin_i;
          num_tiles_d = sched.cfg_num_tiles_i;
          img_base_d  = sched.cfg_img_base_i;
          ch_base_d   = sched.cfg_img_base_i;
          cin_cnt_d   = '0;
          tile_cnt_d  = '0;
          // An empty layer still reports done so the layer FSM never stalls
          if ((sched.cfg_num_cin_i == '0) || (sched.cfg_num_tiles_i == '0)) state_d = DONE;
          else state_d = LOAD_W;
        end
      end
      LOAD_W: begin
        sched.wload_req_o = 1'b1;
        if (sched.wload_ack_i) begin
          // Snapshot so the generator sees a stable base until the next launch
          gen_base_d = ch_base_q;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        sched.gen_start_o = 1'b1;
        state_d           = STREAM;
      end
      STREAM: begin
        if (sched.gen_last_i) begin
          if (cin_cnt_q != num_cin_q - CIN_W'(1)) begin
            cin_cnt_d = cin_cnt_q + CIN_W'(1);
            ch_base_d = ch_base_q + STRIDE_A;
            state_d   = LOAD_W;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        sched.drain_start_o = 1'b1;
        state_d             = WAIT_DRAIN;
      end
      WAIT_DRAIN: begin
        if (sched.drain_done_i) begin
          if (tile_cnt_q != num_tiles_q - TILE_W'(1)) begin
            tile_cnt_d = tile_cnt_q + TILE_W'(1);
            cin_cnt_d  = '0;
            ch_base_d  = img_base_q;
            state_d    = LOAD_W;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        sched.done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator flags only mean something while a channel is in flight
  assign in_channel            = (state_q == LOAD_W) || (state_q == LAUNCH) || (state_q == STREAM);
  assign sched.acc_first_o     = in_channel && (cin_cnt_q == '0);
  assign sched.acc_last_o      = in_channel && (cin_cnt_q == num_cin_q - CIN_W'(1));
  assign sched.busy_o          = (state_q != IDLE);
  assign sched.wload_tile_o    = tile_cnt_q;
  assign sched.wload_cin_o     = cin_cnt_q;
  assign sched.gen_base_addr_o = gen_base_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Randomized bench for conv_layer_scheduler against a loop-level layer model.
// Latency: checks every handshake response on the exact expected cycle.
// Backpressure: responders insert random delays and stray pulses.
module tb_conv_layer_scheduler;

  localparam int AW     = 12;
  localparam int STRIDE = 784;
  localparam int CW     = 7;
  localparam int TW     = 5;

  logic clk_i;
  logic rst_async_i;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_gs  = 0;
  int   n_ds  = 0;
  int   n_dn  = 0;

  conv_layer_scheduler_if #(.SRAM_ADDR_W(AW), .CIN_W(CW), .TILE_W(TW)) bus ();

  conv_layer_scheduler #(
    .SRAM_ADDR_W(AW),
    .MAX_CIN    (64),
    .MAX_TILES  (16),
    .CH_STRIDE  (STRIDE)
  ) dut (
    .clk_i      (clk_i),
    .rst_async_i(rst_async_i),
    .sched      (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Pulse counters, sampled just after each rising edge
  always @(posedge clk_i) begin
    #1;
    if (bus.gen_start_o)   n_gs = n_gs + 1;
    if (bus.drain_start_o) n_ds = n_ds + 1;
    if (bus.done_o)        n_dn = n_dn + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.busy_o, bus.done_o, bus.wload_req_o, bus.wload_tile_o, bus.wload_cin_o,
                bus.gen_start_o, bus.gen_base_addr_o, bus.acc_first_o, bus.acc_last_o,
                bus.drain_start_o});
  endfunction

  task automatic scramble_cfg();
    bus.cfg_img_base_i  = AW'($urandom);
    bus.cfg_num_cin_i   = CW'($urandom_range(0, 64));
    bus.cfg_num_tiles_i = TW'($urandom_range(0, 16));
  endtask

  // Stray input for one cycle; kinds: 1 ack, 2 gen_last, 3 drain_done, 4 start. 'legal' is never poked.
  task automatic poke(input int legal);
    int k;
    k = int'($urandom_range(0, 5));
    if (k == legal) k = 0;
    case (k)
      1: bus.wload_ack_i  = 1'b1;
      2: bus.gen_last_i   = 1'b1;
      3: bus.drain_done_i = 1'b1;
      4: begin scramble_cfg(); bus.start_i = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic unpoke();
    bus.wload_ack_i  = 1'b0;
    bus.gen_last_i   = 1'b0;
    bus.drain_done_i = 1'b0;
    bus.start_i      = 1'b0;
  endtask

  // Runs one layer; expected launch order is the tile/channel nest with base + c*STRIDE mod 2^AW
  task automatic run_layer(input logic [AW-1:0] base, input int nc, input int nt,
                           input int abort_cin, input bit long_ack);
    int gs0, ds0, dn0, ack_d, lat;
    bit aborted;
    logic [AW-1:0] eb;
    aborted = 1'b0;
    gs0 = n_gs; ds0 = n_ds; dn0 = n_dn;
    bus.cfg_img_base_i  = base;
    bus.cfg_num_cin_i   = CW'(nc);
    bus.cfg_num_tiles_i = TW'(nt);
    bus.start_i         = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    scramble_cfg();
    if (nc == 0 || nt == 0) begin
      check_eq("zero_done", 32'(bus.done_o), 32'd1);
      check_eq("zero_busy", 32'(bus.busy_o), 32'd1);
      check_eq("zero_req", 32'(bus.wload_req_o), 32'd0);
      @(negedge clk_i);
      check_eq("zero_done_end", 32'(bus.done_o), 32'd0);
      check_eq("zero_idle", 32'(bus.busy_o), 32'd0);
    end else begin
      for (int t = 0; t < nt && !aborted; t++) begin
        for (int c = 0; c < nc && !aborted; c++) begin
          eb = AW'((int'(base) + c * STRIDE) % (1 << AW));
          check_eq("req_vld", 32'(bus.wload_req_o), 32'd1);
          check_eq("req_tile", 32'(bus.wload_tile_o), 32'(t));
          check_eq("req_cin", 32'(bus.wload_cin_o), 32'(c));
          check_eq("req_first", 32'(bus.acc_first_o), 32'(c == 0));
          check_eq("req_last", 32'(bus.acc_last_o), 32'(c == nc - 1));
          check_eq("req_busy", 32'(bus.busy_o), 32'd1);
          ack_d = (long_ack && t == 0 && c == 0) ? 7 : int'($urandom_range(0, 3));
          for (int k = 0; k < ack_d; k++) begin
            poke(1);
            @(negedge clk_i);
            unpoke();
            check_eq("req_held", 32'(bus.wload_req_o), 32'd1);
            check_eq("no_early_launch", 32'(bus.gen_start_o), 32'd0);
          end
          bus.wload_ack_i = 1'b1;
          @(negedge clk_i);
          bus.wload_ack_i = 1'b0;
          check_eq("launch", 32'(bus.gen_start_o), 32'd1);
          check_eq("launch_base", 32'(bus.gen_base_addr_o), 32'(eb));
          check_eq("launch_first", 32'(bus.acc_first_o), 32'(c == 0));
          check_eq("launch_last", 32'(bus.acc_last_o), 32'(c == nc - 1));
          check_eq("req_dropped", 32'(bus.wload_req_o), 32'd0);
          @(negedge clk_i);
          check_eq("launch_pulse", 32'(bus.gen_start_o), 32'd0);
          check_eq("base_held", 32'(bus.gen_base_addr_o), 32'(eb));
          check_eq("stream_first", 32'(bus.acc_first_o), 32'(c == 0));
          check_eq("stream_last", 32'(bus.acc_last_o), 32'(c == nc - 1));
          if (t == 0 && c == abort_cin) begin
            #2 rst_async_i = 1'b1;
            #1 check_eq("abort_outs_zero", all_outs(), 32'd0);
            @(negedge clk_i);
            #3 rst_async_i = 1'b0;
            @(negedge clk_i);
            check_eq("abort_idle", all_outs(), 32'd0);
            check_eq("abort_no_done", 32'(n_dn - dn0), 32'd0);
            aborted = 1'b1;
          end else begin
            lat = int'($urandom_range(0, 4));
            for (int k = 0; k < lat; k++) begin
              poke(2);
              @(negedge clk_i);
              unpoke();
            end
            bus.gen_last_i = 1'b1;
            @(negedge clk_i);
            bus.gen_last_i = 1'b0;
            if (c == nc - 1) begin
              check_eq("drain_start", 32'(bus.drain_start_o), 32'd1);
              check_eq("drain_no_req", 32'(bus.wload_req_o), 32'd0);
              check_eq("drain_flags", 32'({bus.acc_first_o, bus.acc_last_o}), 32'd0);
            end
          end
        end
        if (!aborted) begin
          @(negedge clk_i);
          check_eq("drain_pulse", 32'(bus.drain_start_o), 32'd0);
          check_eq("drain_busy", 32'(bus.busy_o), 32'd1);
          lat = int'($urandom_range(0, 3));
          for (int k = 0; k < lat; k++) begin
            poke(3);
            @(negedge clk_i);
            unpoke();
          end
          bus.drain_done_i = 1'b1;
          @(negedge clk_i);
          bus.drain_done_i = 1'b0;
          if (t == nt - 1) begin
            check_eq("done", 32'(bus.done_o), 32'd1);
            check_eq("done_busy", 32'(bus.busy_o), 32'd1);
            check_eq("done_no_req", 32'(bus.wload_req_o), 32'd0);
            // start coincident with done must be ignored
            bus.cfg_num_cin_i   = CW'(2);
            bus.cfg_num_tiles_i = TW'(1);
            bus.start_i         = 1'b1;
            @(negedge clk_i);
            bus.start_i = 1'b0;
            check_eq("done_pulse", 32'(bus.done_o), 32'd0);
            check_eq("idle_busy", 32'(bus.busy_o), 32'd0);
            check_eq("idle_req", 32'(bus.wload_req_o), 32'd0);
          end
        end
      end
    end
    if (!aborted) begin
      check_eq("n_launch", 32'(n_gs - gs0), 32'((nc == 0 || nt == 0) ? 0 : nc * nt));
      check_eq("n_drain", 32'(n_ds - ds0), 32'((nc == 0 || nt == 0) ? 0 : nt));
      check_eq("n_done", 32'(n_dn - dn0), 32'd1);
    end
  endtask

  initial begin
    rst_async_i         = 1'b1;
    bus.start_i         = 1'b0;
    bus.cfg_img_base_i  = '0;
    bus.cfg_num_cin_i   = '0;
    bus.cfg_num_tiles_i = '0;
    bus.wload_ack_i     = 1'b0;
    bus.gen_last_i      = 1'b0;
    bus.drain_done_i    = 1'b0;
    #1 check_eq("reset_outs", all_outs(), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_async_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_reset_outs", all_outs(), 32'd0);

    run_layer(12'h100, 3, 1, -1, 1'b0);   // bases 0x100, 0x410, 0x720
    run_layer(12'h100, 2, 2, -1, 1'b0);   // tile sweep
    run_layer(12'h100, 0, 4, -1, 1'b0);   // empty layer
    run_layer(12'h080, 5, 0, -1, 1'b0);
    run_layer(12'h200, 2, 1, -1, 1'b1);   // 7-cycle ack delay
    run_layer(12'hF00, 2, 1, -1, 1'b0);   // second base wraps to 0x210
    run_layer(12'h300, 3, 1, 1, 1'b0);    // reset during cin1 stream
    run_layer(12'h300, 2, 1, -1, 1'b0);
    run_layer(12'h000, 64, 1, -1, 1'b0);
    run_layer(12'h010, 1, 16, -1, 1'b0);
    repeat (25) begin
      run_layer(AW'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 3)),
                -1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
